// File: rtl/oddr_gearbox_pkg.sv
// oddr_gearbox_pkg: shared constants, the PHASE width helper and the
// lane slicing macro used by the DDR output gearbox.

`ifndef ODDR_GEARBOX_PKG_SV
`define ODDR_GEARBOX_PKG_SV

// Selects lane c of a packed bus whose lanes are w bits wide.
`define ODDR_GEARBOX_LANE(c, w) (c)*(w) +: (w)

package oddr_gearbox_pkg;

    // Legal range for the number of clock cycles per word.
    localparam int RATIO_MIN = 1;
    localparam int RATIO_MAX = 8;

    // Width of the phase counter; a one-cycle word still gets a 1-bit port.
    function automatic int phase_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

`endif

// File: rtl/oddr_gearbox_lane.sv
// oddr_gearbox_lane: one lane's word shifter, the posedge/negedge output
// stage and the Q0 clock mux plus the registered Q1 tristate enable.

module oddr_gearbox_lane
    import oddr_gearbox_pkg::*;
#(
    parameter int   RATIO     = 4,
    parameter logic INIT      = 1'b0,
    parameter logic IDLE_TS   = 1'b1,
    parameter logic TXCLK_POL = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [2*RATIO-1:0] load_data,
    input  logic               load_ts,
    output logic               q0,
    output logic               q1
);

    localparam int WORD_W = 2 * RATIO;

    logic [WORD_W-1:0] shift_data;
    logic              shift_ts;
    logic              even_pos;
    logic              even_neg;
    logic              odd_mid;
    logic              odd_pos;
    logic              ts_mid;
    logic              ts_pos;
    logic              ts_neg;

    // Word shifter: load a whole word at a boundary, otherwise step to the next pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_data <= {WORD_W{INIT}};
            shift_ts   <= IDLE_TS;
        end else if (load) begin
            shift_data <= load_data;
            shift_ts   <= load_ts;
        end else begin
            shift_data <= shift_data >> 2;
        end
    end

    // Posedge stage: capture the current pair, delay odd bit and TS one more cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            even_pos <= INIT;
            odd_mid  <= INIT;
            odd_pos  <= INIT;
            ts_mid   <= IDLE_TS;
            ts_pos   <= IDLE_TS;
        end else begin
            even_pos <= shift_data[0];
            odd_mid  <= shift_data[1];
            odd_pos  <= odd_mid;
            ts_mid   <= shift_ts;
            ts_pos   <= ts_mid;
        end
    end

    // Negedge stage: the even bit and the early TS move half a cycle later.
    always_ff @(negedge clk) begin
        if (reset) begin
            even_neg <= INIT;
            ts_neg   <= IDLE_TS;
        end else begin
            even_neg <= even_pos;
            ts_neg   <= ts_mid;
        end
    end

    assign q0 = clk ? even_neg : odd_pos;
    assign q1 = TXCLK_POL ? ts_neg : ts_pos;

endmodule

// File: rtl/oddr_gearbox.sv
// oddr_gearbox: parametrised DDR output serializer. Holds the phase counter,
// the one-entry holding register and the valid/ready handshake, and fans the
// selected word out to CHANNELS lane serializers.
// Optional build macro ODDR_GEARBOX_TRAIN_EN adds the TRAIN input and the
// TRAIN_PATTERN parameter for link training.

module oddr_gearbox
    import oddr_gearbox_pkg::*;
#(
    parameter int   CHANNELS  = 1,
    parameter int   RATIO     = 4,
    parameter logic INIT      = 1'b0,
    parameter logic IDLE_TS   = 1'b1,
    parameter logic TXCLK_POL = 1'b0
`ifdef ODDR_GEARBOX_TRAIN_EN
    ,
    parameter logic [2*RATIO-1:0] TRAIN_PATTERN = {RATIO{2'b01}}
`endif
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic [CHANNELS*2*RATIO-1:0]       DIN,
    input  logic                              TIN,
    input  logic                              DIN_VALID,
    output logic                              DIN_READY,
    output logic [CHANNELS-1:0]               Q0,
    output logic [CHANNELS-1:0]               Q1,
    output logic [phase_width(RATIO)-1:0]     PHASE,
    output logic                              UNDERRUN
`ifdef ODDR_GEARBOX_TRAIN_EN
    ,
    input  logic                              TRAIN
`endif
);

    localparam int            WORD_W     = 2 * RATIO;
    localparam int            BUS_W      = CHANNELS * WORD_W;
    localparam int            PW         = phase_width(RATIO);
    localparam logic [PW-1:0] LAST_PHASE = PW'(RATIO - 1);

    if (RATIO < RATIO_MIN || RATIO > RATIO_MAX) begin : g_ratio_check
        $error("oddr_gearbox: RATIO out of range");
    end

    logic [PW-1:0]    phase;
    logic             boundary;
    logic             training;
    logic             accept;
    logic             hold_full;
    logic [BUS_W-1:0] hold_data;
    logic             hold_ts;
    logic [BUS_W-1:0] load_data;
    logic             load_ts;
    logic             underrun;

`ifdef ODDR_GEARBOX_TRAIN_EN
    assign training = TRAIN;
`else
    assign training = 1'b0;
`endif

    assign boundary  = (phase == LAST_PHASE);
    // During training the boundary never drains the hold, so it must not open READY.
    assign DIN_READY = !hold_full || (boundary && !training);
    assign accept    = DIN_VALID && DIN_READY;
    assign PHASE     = phase;
    assign UNDERRUN  = underrun;

    // Phase counter: counts pairs within a word and wraps at each boundary.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            phase <= '0;
        end else if (boundary) begin
            phase <= '0;
        end else begin
            phase <= phase + PW'(1);
        end
    end

    // Holding register: a new accept always wins over draining to the shifter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            hold_ts   <= IDLE_TS;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= DIN;
            hold_ts   <= TIN;
        end else if (boundary && !training) begin
            hold_full <= 1'b0;
        end
    end

    // Underrun flag: one-cycle pulse after a boundary that had to load an idle word.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            underrun <= 1'b0;
        end else begin
            underrun <= boundary && !hold_full && !training;
        end
    end

    // Boundary word select: training pattern, else held word, else idle word.
    always_comb begin
        load_data = {BUS_W{INIT}};
        load_ts   = IDLE_TS;
        if (hold_full) begin
            load_data = hold_data;
            load_ts   = hold_ts;
        end
`ifdef ODDR_GEARBOX_TRAIN_EN
        if (TRAIN) begin
            load_data = {CHANNELS{TRAIN_PATTERN}};
            load_ts   = 1'b0;
        end
`endif
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        oddr_gearbox_lane #(
            .RATIO     (RATIO),
            .INIT      (INIT),
            .IDLE_TS   (IDLE_TS),
            .TXCLK_POL (TXCLK_POL)
        ) u_lane (
            .clk       (CLK),
            .reset     (RESET),
            .load      (boundary),
            .load_data (load_data[`ODDR_GEARBOX_LANE(c, WORD_W)]),
            .load_ts   (load_ts),
            .q0        (Q0[c]),
            .q1        (Q1[c])
        );
    end

endmodule

// File: tb/tb_oddr_gearbox.sv
// tb_oddr_gearbox: directed self-checking bench. Main DUT is 2 lanes at
// RATIO=4; a second DUT covers RATIO=1 with the negedge-aligned Q1 stage.
// Period e means the clock period that starts at the e-th posedge after reset.

module tb_oddr_gearbox;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] din = '0;
    logic        tin = 1'b0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [1:0]  q0;
    logic [1:0]  q1;
    logic [1:0]  phase;
    logic        underrun;
    logic        train = 1'b0;

    logic [1:0]  r1_din = '0;
    logic        r1_tin = 1'b0;
    logic        r1_valid = 1'b0;
    logic        r1_ready;
    logic        r1_q0;
    logic        r1_q1;
    logic [0:0]  r1_phase;
    logic        r1_underrun;

    int checks_total = 0;
    int checks_passed = 0;

    always #5 CLK = ~CLK;

    oddr_gearbox #(
        .CHANNELS  (2),
        .RATIO     (4),
        .INIT      (1'b0),
        .IDLE_TS   (1'b1),
        .TXCLK_POL (1'b0)
    ) u_dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .DIN       (din),
        .TIN       (tin),
        .DIN_VALID (din_valid),
        .DIN_READY (din_ready),
        .Q0        (q0),
        .Q1        (q1),
        .PHASE     (phase),
        .UNDERRUN  (underrun)
`ifdef ODDR_GEARBOX_TRAIN_EN
        ,
        .TRAIN     (train)
`endif
    );

    oddr_gearbox #(
        .CHANNELS  (1),
        .RATIO     (1),
        .INIT      (1'b0),
        .IDLE_TS   (1'b1),
        .TXCLK_POL (1'b1)
    ) u_dut_r1 (
        .CLK       (CLK),
        .RESET     (RESET),
        .DIN       (r1_din),
        .TIN       (r1_tin),
        .DIN_VALID (r1_valid),
        .DIN_READY (r1_ready),
        .Q0        (r1_q0),
        .Q1        (r1_q1),
        .PHASE     (r1_phase),
        .UNDERRUN  (r1_underrun)
`ifdef ODDR_GEARBOX_TRAIN_EN
        ,
        .TRAIN     (1'b0)
`endif
    );

    // Moves to just after the next posedge (high half of the new period).
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Moves to just after the next negedge (low half of the current period).
    task automatic to_low();
        @(negedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        din_valid = 1'b0;
        r1_valid = 1'b0;
        train = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks_total++;
        if (q0 !== 2'b00) $display("[TB] FAIL reset_q0 got=%b want=00", q0);
        else checks_passed++;
        checks_total++;
        if (q1 !== 2'b11) $display("[TB] FAIL reset_q1 got=%b want=11", q1);
        else checks_passed++;
        checks_total++;
        if (din_ready !== 1'b1) $display("[TB] FAIL reset_ready got=%b want=1", din_ready);
        else checks_passed++;
        checks_total++;
        if (underrun !== 1'b0) $display("[TB] FAIL reset_underrun got=%b want=0", underrun);
        else checks_passed++;
        checks_total++;
        if (phase !== 2'd0) $display("[TB] FAIL reset_phase got=%0d want=0", phase);
        else checks_passed++;
        checks_total++;
        if ({r1_q0, r1_q1, r1_ready, r1_underrun} !== 4'b0110)
            $display("[TB] FAIL reset_r1 got=%b want=0110", {r1_q0, r1_q1, r1_ready, r1_underrun});
        else checks_passed++;
        to_low();
        checks_total++;
        if (q0 !== 2'b00) $display("[TB] FAIL reset_q0_low got=%b want=00", q0);
        else checks_passed++;
    endtask

    task automatic test_idle();
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            tick();
            checks_total++;
            if (underrun !== (e % 4 == 0))
                $display("[TB] FAIL idle_underrun e=%0d got=%b want=%b", e, underrun, (e % 4 == 0));
            else checks_passed++;
            checks_total++;
            if (phase !== 2'(e % 4)) $display("[TB] FAIL idle_phase e=%0d got=%0d want=%0d", e, phase, e % 4);
            else checks_passed++;
            checks_total++;
            if ({q0, q1, din_ready} !== 5'b00111)
                $display("[TB] FAIL idle_pins e=%0d got=%b want=00111", e, {q0, q1, din_ready});
            else checks_passed++;
        end
    endtask

    task automatic test_single_word(input logic [7:0] l0, input logic [7:0] l1, input logic t);
        logic [1:0] exp_hi;
        logic [1:0] exp_lo;
        logic [1:0] exp_q1;
        int         k;
        do_reset();
        din = {l1, l0};
        tin = t;
        din_valid = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 1) begin
                din_valid = 1'b0;
                din = ~{l1, l0};
                tin = ~t;
            end
            exp_hi = 2'b00;
            exp_lo = 2'b00;
            exp_q1 = 2'b11;
            if (e >= 6 && e <= 9) begin
                k = e - 6;
                exp_hi = {l1[2*k], l0[2*k]};
                exp_lo = {l1[2*k+1], l0[2*k+1]};
                exp_q1 = {t, t};
            end
            checks_total++;
            if (q0 !== exp_hi) $display("[TB] FAIL single_q0_hi w=%h e=%0d got=%b want=%b", l0, e, q0, exp_hi);
            else checks_passed++;
            checks_total++;
            if (q1 !== exp_q1) $display("[TB] FAIL single_q1 w=%h e=%0d got=%b want=%b", l0, e, q1, exp_q1);
            else checks_passed++;
            checks_total++;
            if (underrun !== (e % 4 == 0 && e != 4))
                $display("[TB] FAIL single_underrun w=%h e=%0d got=%b", l0, e, underrun);
            else checks_passed++;
            checks_total++;
            if (din_ready !== (e >= 3)) $display("[TB] FAIL single_ready w=%h e=%0d got=%b want=%b", l0, e, din_ready, (e >= 3));
            else checks_passed++;
            to_low();
            checks_total++;
            if (q0 !== exp_lo) $display("[TB] FAIL single_q0_lo w=%h e=%0d got=%b want=%b", l0, e, q0, exp_lo);
            else checks_passed++;
            checks_total++;
            if (q1 !== exp_q1) $display("[TB] FAIL single_q1_lo w=%h e=%0d got=%b want=%b", l0, e, q1, exp_q1);
            else checks_passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic       mfull;
        logic       exp_acc;
        logic [7:0] w;
        logic [7:0] wexp;
        logic [1:0] exp_hi;
        logic [1:0] exp_lo;
        int         j;
        int         k;
        do_reset();
        mfull = 1'b0;
        j = 0;
        din_valid = 1'b1;
        tin = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            w = 8'h10 + 8'(j);
            din = {~w, w};
            exp_acc = !mfull || ((e - 1) % 4 == 3);
            tick();
            if (exp_acc) begin
                mfull = 1'b1;
                j++;
            end else if ((e - 1) % 4 == 3) begin
                mfull = 1'b0;
            end
            checks_total++;
            if (din_ready !== (!mfull || (e % 4 == 3)))
                $display("[TB] FAIL b2b_ready e=%0d got=%b want=%b", e, din_ready, (!mfull || (e % 4 == 3)));
            else checks_passed++;
            checks_total++;
            if (underrun !== 1'b0) $display("[TB] FAIL b2b_underrun e=%0d got=%b want=0", e, underrun);
            else checks_passed++;
            exp_hi = 2'b00;
            exp_lo = 2'b00;
            if (e >= 6) begin
                wexp = 8'h10 + 8'((e - 6) / 4);
                k = (e - 6) % 4;
                exp_hi = {~wexp[2*k], wexp[2*k]};
                exp_lo = {~wexp[2*k+1], wexp[2*k+1]};
            end
            checks_total++;
            if (q1 !== ((e >= 6) ? 2'b00 : 2'b11)) $display("[TB] FAIL b2b_q1 e=%0d got=%b", e, q1);
            else checks_passed++;
            checks_total++;
            if (q0 !== exp_hi) $display("[TB] FAIL b2b_q0_hi e=%0d got=%b want=%b", e, q0, exp_hi);
            else checks_passed++;
            to_low();
            checks_total++;
            if (q0 !== exp_lo) $display("[TB] FAIL b2b_q0_lo e=%0d got=%b want=%b", e, q0, exp_lo);
            else checks_passed++;
        end
        din_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        din = 16'hFFFF;
        tin = 1'b0;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        checks_total++;
        if ({q0, q1, din_ready, underrun} !== 6'b001110)
            $display("[TB] FAIL rstmid_pins got=%b want=001110", {q0, q1, din_ready, underrun});
        else checks_passed++;
        checks_total++;
        if (phase !== 2'd0) $display("[TB] FAIL rstmid_phase got=%0d want=0", phase);
        else checks_passed++;
        to_low();
        checks_total++;
        if (q0 !== 2'b00) $display("[TB] FAIL rstmid_q0_low got=%b want=00", q0);
        else checks_passed++;
        for (int e = 1; e <= 12; e++) begin
            tick();
            checks_total++;
            if ({q0, q1} !== 4'b0011) $display("[TB] FAIL rstmid_hi e=%0d got=%b want=0011", e, {q0, q1});
            else checks_passed++;
            checks_total++;
            if (underrun !== (e % 4 == 0)) $display("[TB] FAIL rstmid_underrun e=%0d got=%b", e, underrun);
            else checks_passed++;
            to_low();
            checks_total++;
            if (q0 !== 2'b00) $display("[TB] FAIL rstmid_lo e=%0d got=%b want=00", e, q0);
            else checks_passed++;
        end
    endtask

    task automatic test_ratio1();
        logic [1:0] words [6];
        logic       tins [6];
        logic       exp_q0;
        logic       exp_q1;
        int         j;
        words = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b01};
        tins  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int e = 1; e <= 11; e++) begin
            if (e <= 6) begin
                r1_din = words[e-1];
                r1_tin = tins[e-1];
                r1_valid = 1'b1;
            end else begin
                r1_valid = 1'b0;
            end
            tick();
            j = e - 4;
            exp_q0 = (j >= 0 && j < 6) ? words[j][0] : 1'b0;
            exp_q1 = (j >= 0 && j < 6) ? tins[j] : 1'b1;
            checks_total++;
            if (r1_q0 !== exp_q0) $display("[TB] FAIL r1_q0_hi e=%0d got=%b want=%b", e, r1_q0, exp_q0);
            else checks_passed++;
            checks_total++;
            if (r1_q1 !== exp_q1) $display("[TB] FAIL r1_q1_hi e=%0d got=%b want=%b", e, r1_q1, exp_q1);
            else checks_passed++;
            checks_total++;
            if (r1_underrun !== (e == 1 || e >= 8)) $display("[TB] FAIL r1_underrun e=%0d got=%b", e, r1_underrun);
            else checks_passed++;
            checks_total++;
            if ({r1_ready, r1_phase} !== 2'b10) $display("[TB] FAIL r1_ready_phase e=%0d got=%b want=10", e, {r1_ready, r1_phase});
            else checks_passed++;
            to_low();
            exp_q0 = (j >= 0 && j < 6) ? words[j][1] : 1'b0;
            j = e - 3;
            exp_q1 = (j >= 0 && j < 6) ? tins[j] : 1'b1;
            checks_total++;
            if (r1_q0 !== exp_q0) $display("[TB] FAIL r1_q0_lo e=%0d got=%b want=%b", e, r1_q0, exp_q0);
            else checks_passed++;
            checks_total++;
            if (r1_q1 !== exp_q1) $display("[TB] FAIL r1_q1_lo e=%0d got=%b want=%b", e, r1_q1, exp_q1);
            else checks_passed++;
        end
    endtask

`ifdef ODDR_GEARBOX_TRAIN_EN
    task automatic test_train();
        logic [1:0] exp_hi;
        logic [1:0] exp_lo;
        logic [1:0] exp_q1;
        do_reset();
        din = 16'hFFFF;
        tin = 1'b0;
        for (int e = 1; e <= 19; e++) begin
            train = (e <= 8);
            din_valid = (e == 1);
            tick();
            exp_hi = 2'b00;
            exp_lo = 2'b00;
            exp_q1 = 2'b11;
            if (e >= 6 && e <= 13) begin
                exp_hi = 2'b11;
                exp_q1 = 2'b00;
            end else if (e >= 14 && e <= 17) begin
                exp_hi = 2'b11;
                exp_lo = 2'b11;
                exp_q1 = 2'b00;
            end
            checks_total++;
            if (q0 !== exp_hi) $display("[TB] FAIL train_q0_hi e=%0d got=%b want=%b", e, q0, exp_hi);
            else checks_passed++;
            checks_total++;
            if (q1 !== exp_q1) $display("[TB] FAIL train_q1 e=%0d got=%b want=%b", e, q1, exp_q1);
            else checks_passed++;
            checks_total++;
            if (underrun !== (e == 16)) $display("[TB] FAIL train_underrun e=%0d got=%b", e, underrun);
            else checks_passed++;
            checks_total++;
            if (din_ready !== (e >= 11)) $display("[TB] FAIL train_ready e=%0d got=%b want=%b", e, din_ready, (e >= 11));
            else checks_passed++;
            to_low();
            checks_total++;
            if (q0 !== exp_lo) $display("[TB] FAIL train_q0_lo e=%0d got=%b want=%b", e, q0, exp_lo);
            else checks_passed++;
        end
        train = 1'b0;
        din_valid = 1'b0;
    endtask
`endif

    // Runs every scenario in order and prints the summary.
    initial begin
        $display("[TB] oddr_gearbox bench start");
        test_reset();
        test_idle();
        test_single_word(8'hB4, 8'h5A, 1'b0);
        test_single_word(8'hFF, 8'h00, 1'b0);
        test_single_word(8'h3C, 8'hC3, 1'b1);
        test_back_to_back();
        test_reset_mid();
        test_ratio1();
`ifdef ODDR_GEARBOX_TRAIN_EN
        test_train();
`endif
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    // Guards against a stalled run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired after %0d checks", checks_total);
        $fatal(1, "[TB] watchdog");
    end

endmodule
